// File: rtl/calc_regfile.sv
// Calculator register file: 2**AW x DW, one write port, two gated read ports.
// Per-entry valid bits, write bypass, optional registered read, clear sweep.
module calc_regfile #(
  parameter int DW       = 3,
  parameter int AW       = 2,
  parameter int READ_REG = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rea,
  input  logic [AW-1:0] raa,
  input  logic          reb,
  input  logic [AW-1:0] rab,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          busy,
  output logic [DW-1:0] douta,
  output logic [DW-1:0] doutb,
  output logic          va,
  output logic          vb
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic            r_busy;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;

  logic            w_wr;
  logic [DW-1:0]   w_rda;
  logic [DW-1:0]   w_rdb;
  logic            w_rva;
  logic            w_rvb;

  // Writes are only accepted outside the sweep; dropped, never deferred.
  assign w_wr = we && !r_busy;
  assign busy = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else if (r_busy) begin
      r_mem[r_ptr]   <= '0;
      r_valid[r_ptr] <= 1'b0;
    end else if (w_wr) begin
      r_mem[wa]   <= din;
      r_valid[wa] <= 1'b1;
    end
  end

  always_comb begin
    w_rda = '0;
    w_rva = 1'b0;
    if (rea) begin
      if (w_wr && (wa == raa)) begin
        w_rda = din;
        w_rva = 1'b1;
      end else begin
        w_rda = r_mem[raa];
        w_rva = r_valid[raa];
      end
    end
  end

  always_comb begin
    w_rdb = '0;
    w_rvb = 1'b0;
    if (reb) begin
      if (w_wr && (wa == rab)) begin
        w_rdb = din;
        w_rvb = 1'b1;
      end else begin
        w_rdb = r_mem[rab];
        w_rvb = r_valid[rab];
      end
    end
  end

  generate
    if (READ_REG != 0) begin : g_rreg
      logic [DW-1:0] r_douta;
      logic [DW-1:0] r_doutb;
      logic          r_va;
      logic          r_vb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_douta <= '0;
          r_doutb <= '0;
          r_va    <= 1'b0;
          r_vb    <= 1'b0;
        end else begin
          r_douta <= w_rda;
          r_doutb <= w_rdb;
          r_va    <= w_rva;
          r_vb    <= w_rvb;
        end
      end

      assign douta = r_douta;
      assign doutb = r_doutb;
      assign va    = r_va;
      assign vb    = r_vb;
    end else begin : g_rcomb
      assign douta = w_rda;
      assign doutb = w_rdb;
      assign va    = w_rva;
      assign vb    = w_rvb;
    end
  endgenerate

endmodule

// File: tb/tb_calc_regfile.sv
// Directed bench for calc_regfile: combinational and registered-read
// instances share stimulus and are checked against a behavioural model.
module tb_calc_regfile;
  localparam int DW = 3;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rea, reb, we, clr;
  logic [AW-1:0] raa, rab, wa;
  logic [DW-1:0] din;

  logic          busy0, va0, vb0;
  logic [DW-1:0] douta0, doutb0;
  logic          busy1, va1, vb1;
  logic [DW-1:0] douta1, doutb1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  calc_regfile #(.DW(DW), .AW(AW), .READ_REG(0)) u_comb (
    .clk(clk), .rst_n(rst_n),
    .rea(rea), .raa(raa), .reb(reb), .rab(rab),
    .we(we), .wa(wa), .din(din), .clr(clr),
    .busy(busy0), .douta(douta0), .doutb(doutb0),
    .va(va0), .vb(vb0)
  );

  calc_regfile #(.DW(DW), .AW(AW), .READ_REG(1)) u_reg (
    .clk(clk), .rst_n(rst_n),
    .rea(rea), .raa(raa), .reb(reb), .rab(rab),
    .we(we), .wa(wa), .din(din), .clr(clr),
    .busy(busy1), .douta(douta1), .doutb(doutb1),
    .va(va1), .vb(vb1)
  );

  // Behavioural model
  int m_mem [DEPTH];
  bit m_val [DEPTH];
  bit m_busy;
  int m_left;
  int m_idx;
  int qa_d, qb_d;
  bit qa_v, qb_v;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void rd(input bit en, input int a,
                             output int d, output bit v);
    d = 0;
    v = 0;
    if (en) begin
      if (we && !m_busy && int'(wa) == a) begin
        d = int'(din);
        v = 1;
      end else begin
        d = m_mem[a];
        v = m_val[a];
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = 0;
        m_val[i] = 0;
      end
      m_busy = 0;
      m_left = 0;
      m_idx  = 0;
      qa_d = 0; qa_v = 0; qb_d = 0; qb_v = 0;
    end else begin
      rd(rea, int'(raa), qa_d, qa_v);
      rd(reb, int'(rab), qb_d, qb_v);
      if (!m_busy) begin
        if (we) begin
          m_mem[wa] = int'(din);
          m_val[wa] = 1;
        end
        if (clr) begin
          m_busy = 1;
          m_left = DEPTH;
          m_idx  = 0;
        end
      end else begin
        m_mem[m_idx] = 0;
        m_val[m_idx] = 0;
        m_idx++;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    int ed_a, ed_b;
    bit ev_a, ev_b;
    rd(rea, int'(raa), ed_a, ev_a);
    rd(reb, int'(rab), ed_b, ev_b);
    chk("c_busy",  int'(busy0),  int'(m_busy));
    chk("c_douta", int'(douta0), ed_a);
    chk("c_va",    int'(va0),    int'(ev_a));
    chk("c_doutb", int'(doutb0), ed_b);
    chk("c_vb",    int'(vb0),    int'(ev_b));
    chk("r_busy",  int'(busy1),  int'(m_busy));
    chk("r_douta", int'(douta1), qa_d);
    chk("r_va",    int'(va1),    int'(qa_v));
    chk("r_doutb", int'(doutb1), qb_d);
    chk("r_vb",    int'(vb1),    int'(qb_v));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int nb;

  initial begin
    rst_n = 0;
    rea = 0; reb = 0; we = 0; clr = 0;
    raa = 0; rab = 0; wa = 0; din = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_douta1", int'(douta1), 0);
    cyc();
    rst_n = 1;
    rea = 1; reb = 1; raa = 0; rab = 3;
    @(negedge clk);
    chk("unw_douta", int'(douta0), 0);
    chk("unw_va", int'(va0), 0);
    chk("unw_doutb", int'(doutb0), 0);
    chk("unw_vb", int'(vb0), 0);

    cyc();
    we = 1; wa = 2; din = 5; rea = 0; reb = 0;
    cyc();
    we = 0; rea = 1; raa = 2;
    @(negedge clk);
    chk("wr_douta", int'(douta0), 5);
    chk("wr_va", int'(va0), 1);
    cyc();
    rea = 0;
    @(negedge clk);
    chk("rdis_douta", int'(douta0), 0);
    chk("rdis_va", int'(va0), 0);
    chk("wr_douta_reg", int'(douta1), 5);
    chk("wr_va_reg", int'(va1), 1);

    cyc();
    we = 1; wa = 1; din = 6; rea = 1; raa = 1;
    @(negedge clk);
    chk("byp_douta", int'(douta0), 6);
    chk("byp_va", int'(va0), 1);
    cyc();
    we = 0; rea = 0;
    @(negedge clk);
    chk("byp_douta_reg", int'(douta1), 6);
    chk("byp_va_reg", int'(va1), 1);

    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      we = 1; wa = AW'(i); din = DW'(i + 1);
    end
    cyc();
    we = 0; clr = 1;
    cyc();
    clr = 0;
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      we  = (i == 0);
      wa  = 0;
      din = 7;
      rea = (i == 1);
      raa = 3;
      @(negedge clk);
      if (busy0) nb++;
      if (i == 1) begin
        chk("sw_old_douta", int'(douta0), 4);
        chk("sw_old_va", int'(va0), 1);
      end
      cyc();
    end
    we = 0;
    chk("busy_len", nb, 4);
    rea = 1; reb = 1; raa = 0; rab = 3;
    @(negedge clk);
    chk("sw_e0_douta", int'(douta0), 0);
    chk("sw_e0_va", int'(va0), 0);
    chk("sw_e3_doutb", int'(doutb0), 0);
    chk("sw_e3_vb", int'(vb0), 0);

    cyc();
    clr = 1; we = 1; wa = 3; din = 2; rea = 0; reb = 1; rab = 3;
    @(negedge clk);
    chk("cw_byp_doutb", int'(doutb0), 2);
    cyc();
    clr = 0; we = 0;
    @(negedge clk);
    chk("cw_busy", int'(busy0), 1);
    chk("cw_commit_vb", int'(vb0), 1);
    repeat (5) cyc();
    @(negedge clk);
    chk("cw_doutb", int'(doutb0), 0);
    chk("cw_vb", int'(vb0), 0);

    cyc();
    we = 1; wa = 2; din = 5; reb = 0;
    cyc();
    we = 0; clr = 1;
    cyc();
    clr = 0;
    cyc();
    rea = 1; raa = 2;
    #1;
    chk("mid_pre_douta", int'(douta0), 5);
    chk("mid_pre_busy", int'(busy0), 1);
    #1;
    rst_n = 0;
    #1;
    chk("ar_busy", int'(busy0), 0);
    chk("ar_douta", int'(douta0), 0);
    chk("ar_va", int'(va0), 0);
    chk("ar_busy_reg", int'(busy1), 0);
    chk("ar_douta_reg", int'(douta1), 0);
    chk("ar_va_reg", int'(va1), 0);
    repeat (2) cyc();
    rst_n = 1;
    rea = 0;
    cyc();
    we = 1; wa = 0; din = 3;
    cyc();
    we = 0; rea = 1; raa = 0; reb = 1; rab = 2;
    @(negedge clk);
    chk("post_douta", int'(douta0), 3);
    chk("post_va", int'(va0), 1);
    chk("post_e2_vb", int'(vb0), 0);
    chk("post_busy", int'(busy0), 0);
    cyc();
    @(negedge clk);
    chk("post_douta_reg", int'(douta1), 3);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
